// File: rtl/imem_loader.sv
// Instruction memory program loader.
// Packs a byte stream (first byte most significant) into 32-bit instruction words and
// writes them to consecutive word addresses, stalling the CPU until the load finishes.
module imem_loader #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned CNT_W = 11
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [CNT_W-1:0] load_count_i,
    input  logic             abort_i,
    input  logic [7:0]       byte_in_i,
    input  logic             byte_valid_i,
    output logic             byte_ready_o,
    output logic             wr_en_o,
    output logic [31:0]      wr_addr_o,
    output logic [31:0]      wr_data_o,
    output logic             busy_o,
    output logic             hold_cpu_o,
    output logic             done_o,
    output logic             err_o,
    output logic [CNT_W-1:0] words_written_o
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRecv  = 2'd1;
    localparam logic [1:0] StWrite = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    localparam logic [CNT_W-1:0] DepthC = CNT_W'(DEPTH);

    logic [1:0]       state_q, state_d;
    logic [1:0]       byte_cnt_q, byte_cnt_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0] load_cnt_q, load_cnt_d;
    logic [CNT_W-1:0] words_written_q, words_written_d;
    logic [31:0]      shift_q, shift_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] word_cnt_inc;

    assign word_cnt_inc = word_cnt_q + CNT_W'(1);

    // Next-state logic; abort overrides every state and discards any partial word.
    always_comb begin
        state_d         = state_q;
        byte_cnt_d      = byte_cnt_q;
        word_cnt_d      = word_cnt_q;
        load_cnt_d      = load_cnt_q;
        words_written_d = words_written_q;
        shift_d         = shift_q;
        err_d           = err_q;

        if (abort_i) begin
            state_d    = StIdle;
            byte_cnt_d = 2'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        if (load_count_i == '0) begin
                            // Empty load: nothing written, so the last-load count is zero.
                            state_d         = StDone;
                            err_d           = 1'b0;
                            words_written_d = '0;
                        end else if (load_count_i > DepthC) begin
                            // Rejecting here keeps every write address below DEPTH.
                            err_d = 1'b1;
                        end else begin
                            state_d         = StRecv;
                            err_d           = 1'b0;
                            word_cnt_d      = '0;
                            byte_cnt_d      = 2'd0;
                            words_written_d = '0;
                            load_cnt_d      = load_count_i;
                        end
                    end
                end
                StRecv: begin
                    if (byte_valid_i) begin
                        shift_d    = {shift_q[23:0], byte_in_i};
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            state_d = StWrite;
                        end
                    end
                end
                StWrite: begin
                    word_cnt_d      = word_cnt_inc;
                    words_written_d = words_written_q + CNT_W'(1);
                    state_d         = (word_cnt_inc == load_cnt_q) ? StDone : StRecv;
                end
                StDone: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= StIdle;
            byte_cnt_q      <= 2'd0;
            word_cnt_q      <= '0;
            load_cnt_q      <= '0;
            words_written_q <= '0;
            shift_q         <= '0;
            err_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            byte_cnt_q      <= byte_cnt_d;
            word_cnt_q      <= word_cnt_d;
            load_cnt_q      <= load_cnt_d;
            words_written_q <= words_written_d;
            shift_q         <= shift_d;
            err_q           <= err_d;
        end
    end

    // Outputs decode from registered state; only the write strobe sees abort directly.
    always_comb begin
        byte_ready_o    = (state_q == StRecv);
        wr_en_o         = (state_q == StWrite) && !abort_i;
        busy_o          = (state_q == StRecv) || (state_q == StWrite);
        hold_cpu_o      = busy_o;
        done_o          = (state_q == StDone);
        err_o           = err_q;
        words_written_o = words_written_q;
        // Address and data come straight from registers, so they hold steady in WRITE.
        wr_addr_o       = 32'(word_cnt_q);
        wr_data_o       = shift_q;
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: per-cycle vector table plus directed sequences.
module tb_imem_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [10:0] load_count;
    logic        abort;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        hold_cpu;
    logic        done;
    logic        err;
    logic [10:0] words_written;

    imem_loader #(
        .DEPTH (1024),
        .CNT_W (11)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .start_i         (start),
        .load_count_i    (load_count),
        .abort_i         (abort),
        .byte_in_i       (byte_in),
        .byte_valid_i    (byte_valid),
        .byte_ready_o    (byte_ready),
        .wr_en_o         (wr_en),
        .wr_addr_o       (wr_addr),
        .wr_data_o       (wr_data),
        .busy_o          (busy),
        .hold_cpu_o      (hold_cpu),
        .done_o          (done),
        .err_o           (err),
        .words_written_o (words_written)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int done_cnt = 0;
    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];

    typedef struct {
        logic        st;
        logic [10:0] cnt;
        logic        ab;
        logic        bv;
        logic [7:0]  bi;
        logic        rdy;
        logic        busy;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] data;
        logic        dck;
        logic        done;
        logic        err;
        logic [10:0] ww;
    } vec_t;

    vec_t tbl[25];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input bit st, input int cnt, input bit ab, input bit bv,
                                input int bi, input bit rdy, input bit bsy, input bit wen,
                                input int addr, input logic [31:0] data, input bit dck,
                                input bit dn, input bit er, input int ww);
        vec_t v;
        v.st = st; v.cnt = 11'(cnt); v.ab = ab; v.bv = bv; v.bi = 8'(bi);
        v.rdy = rdy; v.busy = bsy; v.wen = wen; v.addr = 32'(addr); v.data = data;
        v.dck = dck; v.done = dn; v.err = er; v.ww = 11'(ww);
        return v;
    endfunction

    function automatic logic [7:0] bpat(input int i);
        return 8'(i * 37 + (i >> 8) * 11 + 5);
    endfunction

    function automatic logic [31:0] wpat(input int base, input int n);
        return {bpat(base + 4 * n), bpat(base + 4 * n + 1),
                bpat(base + 4 * n + 2), bpat(base + 4 * n + 3)};
    endfunction

    // Write/done monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n && wr_en) begin
            wa_q.push_back(wr_addr);
            wd_q.push_back(wr_data);
            chk("ready_low_in_write", 32'(byte_ready), 32'd0);
        end
        if (rst_n && done) done_cnt++;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int cnt);
        start = 1'b1;
        load_count = 11'(cnt);
        cyc();
        start = 1'b0;
    endtask

    // Feeds n pattern bytes; holds a byte that was offered but not taken.
    task automatic feed(input int n, input int base, input bit gaps, input int budget);
        int idx = 0;
        int cy = 0;
        bit pend = 0;
        bit acc;
        while (idx < n && cy < budget) begin
            if (!pend) byte_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            byte_in = bpat(base + idx);
            @(negedge clk);
            acc = byte_valid && byte_ready;
            cyc();
            if (acc) idx++;
            pend = byte_valid && !acc;
            cy++;
        end
        byte_valid = 1'b0;
        chk("feed_all_bytes", 32'(idx), 32'(n));
    endtask

    task automatic wait_done(input int d0, input int budget);
        int cy = 0;
        while (done_cnt == d0 && cy < budget) begin
            cyc();
            cy++;
        end
        chk("done_pulse_count", 32'(done_cnt - d0), 32'd1);
    endtask

    initial begin
        int w0;
        int d0;
        int bad;

        rst_n = 1'b0; start = 1'b0; load_count = '0; abort = 1'b0;
        byte_in = '0; byte_valid = 1'b0;

        // Rows: inputs for one cycle, then the outputs expected in that same cycle.
        tbl[0]  = mk(0, 0,    0, 0, 0,    0, 0, 0, 0, 32'h0,        1, 0, 0, 0);
        tbl[1]  = mk(1, 1025, 0, 0, 0,    0, 0, 0, 0, 32'h0,        1, 0, 0, 0);
        tbl[2]  = mk(0, 0,    0, 0, 0,    0, 0, 0, 0, 32'h0,        1, 0, 1, 0);
        tbl[3]  = mk(1, 0,    0, 0, 0,    0, 0, 0, 0, 32'h0,        1, 0, 1, 0);
        tbl[4]  = mk(0, 0,    0, 0, 0,    0, 0, 0, 0, 32'h0,        1, 1, 0, 0);
        tbl[5]  = mk(0, 0,    0, 0, 0,    0, 0, 0, 0, 32'h0,        1, 0, 0, 0);
        tbl[6]  = mk(1, 1,    0, 0, 0,    0, 0, 0, 0, 32'h0,        1, 0, 0, 0);
        tbl[7]  = mk(0, 0,    0, 1, 'h20, 1, 1, 0, 0, 32'h0,        1, 0, 0, 0);
        tbl[8]  = mk(0, 0,    0, 1, 'h08, 1, 1, 0, 0, 32'h20,       1, 0, 0, 0);
        tbl[9]  = mk(0, 0,    0, 0, 0,    1, 1, 0, 0, 32'h2008,     1, 0, 0, 0);
        tbl[10] = mk(0, 0,    0, 1, 'h00, 1, 1, 0, 0, 32'h2008,     1, 0, 0, 0);
        tbl[11] = mk(0, 0,    0, 1, 'h05, 1, 1, 0, 0, 32'h200800,   1, 0, 0, 0);
        tbl[12] = mk(0, 0,    0, 1, 'hAA, 0, 1, 1, 0, 32'h20080005, 1, 0, 0, 0);
        tbl[13] = mk(0, 0,    0, 0, 0,    0, 0, 0, 1, 32'h20080005, 1, 1, 0, 1);
        tbl[14] = mk(0, 0,    0, 0, 0,    0, 0, 0, 1, 32'h20080005, 1, 0, 0, 1);
        tbl[15] = mk(1, 2,    0, 0, 0,    0, 0, 0, 1, 32'h20080005, 1, 0, 0, 1);
        tbl[16] = mk(0, 0,    0, 1, 'h11, 1, 1, 0, 0, 32'h0,        0, 0, 0, 0);
        tbl[17] = mk(1, 1025, 0, 1, 'h22, 1, 1, 0, 0, 32'h0,        0, 0, 0, 0);
        tbl[18] = mk(0, 0,    0, 1, 'h33, 1, 1, 0, 0, 32'h0,        0, 0, 0, 0);
        tbl[19] = mk(0, 0,    0, 1, 'h44, 1, 1, 0, 0, 32'h0,        0, 0, 0, 0);
        tbl[20] = mk(0, 0,    1, 0, 0,    0, 1, 0, 0, 32'h11223344, 1, 0, 0, 0);
        tbl[21] = mk(0, 0,    0, 0, 0,    0, 0, 0, 0, 32'h0,        0, 0, 0, 0);
        tbl[22] = mk(1, 1,    1, 0, 0,    0, 0, 0, 0, 32'h0,        0, 0, 0, 0);
        tbl[23] = mk(0, 0,    0, 0, 0,    0, 0, 0, 0, 32'h0,        0, 0, 0, 0);
        tbl[24] = mk(0, 0,    0, 1, 'h55, 0, 0, 0, 0, 32'h0,        0, 0, 0, 0);

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_ww", 32'(words_written), 32'd0);
        chk("rst_data", wr_data, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Cycle-accurate table: zero count, rejected count, single word, abort in WRITE.
        for (int i = 0; i < 25; i++) begin
            start = tbl[i].st; load_count = tbl[i].cnt; abort = tbl[i].ab;
            byte_valid = tbl[i].bv; byte_in = tbl[i].bi;
            @(negedge clk);
            chk($sformatf("v%0d_ready", i), 32'(byte_ready), 32'(tbl[i].rdy));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
            chk($sformatf("v%0d_hold", i), 32'(hold_cpu), 32'(tbl[i].busy));
            chk($sformatf("v%0d_wr_en", i), 32'(wr_en), 32'(tbl[i].wen));
            chk($sformatf("v%0d_addr", i), wr_addr, tbl[i].addr);
            if (tbl[i].dck) chk($sformatf("v%0d_data", i), wr_data, tbl[i].data);
            chk($sformatf("v%0d_done", i), 32'(done), 32'(tbl[i].done));
            chk($sformatf("v%0d_err", i), 32'(err), 32'(tbl[i].err));
            chk($sformatf("v%0d_ww", i), 32'(words_written), 32'(tbl[i].ww));
            cyc();
        end
        start = 1'b0; abort = 1'b0; byte_valid = 1'b0;
        cyc();

        // Back-pressure: three words with random gaps in the byte stream.
        w0 = wa_q.size(); d0 = done_cnt;
        pulse_start(3);
        feed(12, 100, 1'b1, 200);
        wait_done(d0, 20);
        chk("bp_write_count", 32'(wa_q.size() - w0), 32'd3);
        for (int k = 0; k < 3 && w0 + k < wa_q.size(); k++) begin
            chk($sformatf("bp_addr%0d", k), wa_q[w0 + k], 32'(k));
            chk($sformatf("bp_data%0d", k), wd_q[w0 + k], wpat(100, k));
        end
        chk("bp_ww", 32'(words_written), 32'd3);

        // Bounds: one past DEPTH is rejected, exactly DEPTH is loaded in full.
        w0 = wa_q.size();
        pulse_start(1025);
        cyc();
        chk("over_err", 32'(err), 32'd1);
        chk("over_busy", 32'(busy), 32'd0);
        chk("over_no_write", 32'(wa_q.size() - w0), 32'd0);
        d0 = done_cnt;
        pulse_start(1024);
        chk("full_err_cleared", 32'(err), 32'd0);
        feed(4096, 0, 1'b0, 6000);
        wait_done(d0, 20);
        chk("full_write_count", 32'(wa_q.size() - w0), 32'd1024);
        if (wa_q.size() > 0) begin
            chk("full_last_addr", wa_q[wa_q.size() - 1], 32'd1023);
            chk("full_last_data", wd_q[wd_q.size() - 1], wpat(0, 1023));
        end
        bad = 0;
        for (int k = 0; k < 1024 && w0 + k < wa_q.size(); k++) begin
            if (wa_q[w0 + k] !== 32'(k) || wd_q[w0 + k] !== wpat(0, k)) bad++;
        end
        chk("full_bad_words", 32'(bad), 32'd0);
        chk("full_ww", 32'(words_written), 32'd1024);
        cyc();
        chk("full_busy_after", 32'(busy), 32'd0);

        // Abort after six bytes of a four-word load.
        w0 = wa_q.size(); d0 = done_cnt;
        pulse_start(4);
        feed(6, 3000, 1'b0, 20);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        @(negedge clk);
        chk("abort_idle", 32'(busy), 32'd0);
        chk("abort_ww", 32'(words_written), 32'd1);
        repeat (8) cyc();
        chk("abort_writes", 32'(wa_q.size() - w0), 32'd1);
        if (wa_q.size() > w0) begin
            chk("abort_addr", wa_q[w0], 32'd0);
            chk("abort_data", wd_q[w0], wpat(3000, 0));
        end
        chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
        chk("abort_ww_kept", 32'(words_written), 32'd1);

        // Asynchronous reset in RECV with a byte on offer.
        w0 = wa_q.size();
        pulse_start(2);
        feed(2, 4000, 1'b0, 10);
        byte_valid = 1'b1; byte_in = 8'h77;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ready", 32'(byte_ready), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_hold", 32'(hold_cpu), 32'd0);
        chk("arst_wr_en", 32'(wr_en), 32'd0);
        chk("arst_data", wr_data, 32'd0);
        cyc();
        rst_n = 1'b1;
        repeat (10) cyc();
        chk("arst_no_writes", 32'(wa_q.size() - w0), 32'd0);
        chk("arst_still_idle", 32'(busy), 32'd0);
        byte_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
